// File: rtl/clk_sched_pkg.sv
// Shared definitions for the clock-tick scheduler.
// Holds the per-channel state encoding, the tap and prescale widths,
// and the largest supported channel count.
package clk_sched_pkg;

    localparam int unsigned TAP_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned NCH_MAX = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } chan_state_e;

endpackage

// File: rtl/clk_sched_chan.sv
// One tick channel: timebase edge detector, prescale counter and IDLE/RUN/DONE FSM.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clkdiv              free-running divider count (timebase source)
//   cfg_we              configuration write strobe (only issued when not RUN)
//   cfg_tap/count/mode  configuration payload
//   start, stop         level-sampled control requests (stop wins)
//   tick                registered single-cycle pulse
//   busy, done          channel is in RUN / DONE
module clk_sched_chan
    import clk_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic             cfg_we,
    input  logic [TAP_W-1:0] cfg_tap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    chan_state_e      state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             tick_q, tick_d;

    logic [TAP_W-1:0] tap_sel;
    logic             tb_rise;

    // The previous sample always follows the tap that will be in use next
    // cycle, so a tap change on a config write cannot fake a rising edge.
    assign tap_sel = cfg_we ? cfg_tap : tap_q;
    assign tb_rise = clkdiv[tap_q] & ~prev_q;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        count_d = count_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        prev_d  = clkdiv[tap_sel];
        tick_d  = 1'b0;

        if (cfg_we) begin
            tap_d   = cfg_tap;
            count_d = cfg_count;
            mode_d  = cfg_mode;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tb_rise) begin
                    if (cnt_q == count_q) begin
                        tick_d = 1'b1;
                        cnt_d  = '0;
                        if (mode_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cfg_we) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tap_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: rtl/clk_sched.sv
// Multi-channel tick scheduler top level.
// Decodes configuration writes to NCH independent tick channels and drives
// the cfg_ready handshake.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   clkdiv                    free-running divider count (timebase)
//   cfg_valid/cfg_ready       configuration write handshake
//   cfg_ch                    target channel (out-of-range writes are accepted and dropped)
//   cfg_tap/count/mode        configuration payload
//   start, stop               per-channel control requests
//   tick, busy, done          per-channel status
module clk_sched
    import clk_sched_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_ch,
    input  logic [TAP_W-1:0] cfg_tap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_mode,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   done
);

    logic [NCH-1:0] cfg_we;

    // A channel index with no matching channel leaves ready high and
    // selects no write strobe, so the write is handshaken and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        cfg_we    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == 3'(i)) begin
                cfg_ready = ~busy[i];
                cfg_we[i] = cfg_valid & ~busy[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_sched_chan u_chan (
            .clk       (clk),
            .rst       (rst),
            .clkdiv    (clkdiv),
            .cfg_we    (cfg_we[g]),
            .cfg_tap   (cfg_tap),
            .cfg_count (cfg_count),
            .cfg_mode  (cfg_mode),
            .start     (start[g]),
            .stop      (stop[g]),
            .tick      (tick[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

endmodule

// File: tb/tb_clk_sched.sv
// Self-checking bench for clk_sched: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_clk_sched;

    localparam int unsigned NCH = 4;

    logic           clk;
    logic           rst;
    logic [31:0]    clkdiv;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [4:0]     cfg_tap;
    logic [15:0]    cfg_count;
    logic           cfg_mode;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;

    clk_sched #(.NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clkdiv    (clkdiv),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_tap   (cfg_tap),
        .cfg_count (cfg_count),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: state 0=idle 1=run 2=done; edges counts timebase
    // rises seen since the last tick/start.
    int          m_state [NCH];
    int          m_tap   [NCH];
    int          m_count [NCH];
    bit          m_mode  [NCH];
    int          m_edges [NCH];
    bit          m_tick  [NCH];
    logic [31:0] last_div;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt [NCH];
    int gaps0 [$];
    int cyc = 0;
    int last_tick0 = -1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_state[c] = 0;
            m_tap[c]   = 0;
            m_count[c] = 0;
            m_mode[c]  = 1'b0;
            m_edges[c] = 0;
            m_tick[c]  = 1'b0;
        end
        last_div = '0;
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            bit rise;
            wr   = cfg_valid && (int'(cfg_ch) == c) && (m_state[c] != 1);
            rise = clkdiv[m_tap[c]] && !last_div[m_tap[c]];
            m_tick[c] = 1'b0;
            if (stop[c]) begin
                m_state[c] = 0;
                m_edges[c] = 0;
            end else if (start[c] && m_state[c] != 1) begin
                m_state[c] = 1;
                m_edges[c] = 0;
            end else if (m_state[c] == 1 && rise) begin
                m_edges[c]++;
                if (m_edges[c] == m_count[c] + 1) begin
                    m_tick[c]  = 1'b1;
                    m_edges[c] = 0;
                    if (m_mode[c]) m_state[c] = 2;
                end
            end else if (m_state[c] == 2 && wr) begin
                m_state[c] = 0;
            end
            if (wr) begin
                m_tap[c]   = int'(cfg_tap);
                m_count[c] = int'(cfg_count);
                m_mode[c]  = cfg_mode;
            end
        end
        last_div = clkdiv;
    endfunction

    function automatic logic model_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return m_state[cfg_ch] != 1;
    endfunction

    // Compare process: outputs after every rising edge, cfg_ready mid-cycle.
    always begin
        logic [NCH-1:0] e_tick, e_busy, e_done;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            e_tick[c] = m_tick[c];
            e_busy[c] = (m_state[c] == 1);
            e_done[c] = (m_state[c] == 2);
            if (tick[c]) tick_cnt[c]++;
        end
        check("tick", 32'(tick), 32'(e_tick));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        if (tick[0]) begin
            if (last_tick0 >= 0) gaps0.push_back(cyc - last_tick0);
            last_tick0 = cyc;
        end
        @(negedge clk);
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
    end

    task automatic step();
        @(negedge clk);
        clkdiv = clkdiv + 32'd1;
    endtask

    task automatic cfg_write(input int ch, input int tap, input int cnt, input bit mode);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_tap   = 5'(tap);
        cfg_count = 16'(cnt);
        cfg_mode  = mode;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m);
        start = m;
        step();
        start = '0;
    endtask

    task automatic pulse_stop(input logic [NCH-1:0] m);
        stop = m;
        step();
        stop = '0;
    endtask

    task automatic clear_ticks();
        for (int c = 0; c < NCH; c++) tick_cnt[c] = 0;
    endtask

    initial begin
        rst       = 1'b1;
        clkdiv    = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_tap   = '0;
        cfg_count = '0;
        cfg_mode  = 1'b0;
        start     = '0;
        stop      = '0;
        model_reset();
        clear_ticks();

        repeat (2) step();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cfg_ready), 32'h1);

        // ch0 tap=2 count=0 periodic: one tick every 8 clocks
        cfg_write(0, 2, 0, 1'b0);
        pulse_start(4'b0001);
        clear_ticks();
        gaps0.delete();
        last_tick0 = -1;
        repeat (64) step();
        check("ch0_tick_count", 32'(tick_cnt[0]), 32'd8);
        foreach (gaps0[i]) check("ch0_tick_gap", 32'(gaps0[i]), 32'd8);

        // ch1 tap=0 count=3 one-shot: single tick then DONE
        cfg_write(1, 0, 3, 1'b1);
        clear_ticks();
        pulse_start(4'b0010);
        repeat (20) step();
        check("ch1_oneshot_ticks", 32'(tick_cnt[1]), 32'd1);
        check("ch1_done", 32'(done[1]), 32'h1);
        check("ch1_busy", 32'(busy[1]), 32'h0);

        // write to running ch0 is held off and leaves its config alone
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_tap   = 5'd1;
        cfg_count = 16'd1;
        cfg_mode  = 1'b1;
        #1;
        check("ch0_ready_in_run", 32'(cfg_ready), 32'h0);
        step();
        cfg_ch = 3'd5;
        #1;
        check("oor_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        clear_ticks();
        repeat (32) step();
        check("ch0_cfg_unchanged", 32'(tick_cnt[0]), 32'd4);
        pulse_stop(4'b0001);
        check("ch0_stopped", 32'(busy[0]), 32'h0);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        #1;
        check("ch0_ready_idle", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        clear_ticks();
        pulse_start(4'b0001);
        repeat (20) step();
        check("ch0_new_cfg_ticks", 32'(tick_cnt[0]), 32'd1);
        check("ch0_new_cfg_done", 32'(done[0]), 32'h1);

        // start and stop together on idle ch2
        clear_ticks();
        start = 4'b0100;
        stop  = 4'b0100;
        step();
        start = '0;
        stop  = '0;
        check("ch2_start_stop_busy", 32'(busy[2]), 32'h0);
        repeat (10) step();
        check("ch2_no_tick", 32'(tick_cnt[2]), 32'd0);

        // reset mid-run on every channel
        pulse_start(4'b1111);
        repeat (5) step();
        check("all_busy", 32'(busy), 32'hF);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_tick", 32'(tick), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        model_reset();
        step();
        rst = 1'b0;
        clear_ticks();
        repeat (40) step();
        check("no_tick_after_rst",
              32'(tick_cnt[0] + tick_cnt[1] + tick_cnt[2] + tick_cnt[3]), 32'd0);

        // ch3 on bit 31: tick at the rise, none at the wrap to zero
        cfg_write(3, 31, 0, 1'b0);
        clkdiv = 32'h7FFF_FFF0;
        pulse_start(4'b1000);
        clear_ticks();
        repeat (40) step();
        check("ch3_bit31_rise", 32'(tick_cnt[3]), 32'd1);
        clkdiv = 32'hFFFF_FFF0;
        repeat (40) step();
        check("ch3_no_wrap_tick", 32'(tick_cnt[3]), 32'd1);
        check("ch3_still_busy", 32'(busy[3]), 32'h1);
        pulse_stop(4'b1111);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_tap   = 5'($urandom_range(0, 4));
            cfg_count = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
            cfg_mode  = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(0, 15) == 0);
                stop[c]  = ($urandom_range(0, 31) == 0);
            end
            step();
        end
        cfg_valid = 1'b0;
        start     = '0;
        stop      = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_sched.md
CLK_SCHED -- requirements
Module: clk_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, giving the number of independent tick channels (legal range 1..8).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clkdiv  input  32  free-running divider count, sampled as the timebase.
REQ-005 SHALL have port cfg_valid  input  1  configuration write request.
REQ-006 SHALL have port cfg_ready  output  1  configuration write accepted when high together with cfg_valid.
REQ-007 SHALL have port cfg_ch  input  3  target channel index; values >= NCH are dropped but still handshaken.
REQ-008 SHALL have port cfg_tap  input  5  clkdiv bit used as the channel timebase.
REQ-009 SHALL have port cfg_count  input  16  prescale: tick on every (cfg_count+1)-th timebase edge.
REQ-010 SHALL have port cfg_mode  input  1  0 = periodic, 1 = one-shot.
REQ-011 SHALL have port start  input  NCH  per-channel start request, level-sampled each cycle.
REQ-012 SHALL have port stop  input  NCH  per-channel stop request, level-sampled each cycle.
REQ-013 SHALL have port tick  output  NCH  registered single-cycle enable pulse per channel.
REQ-014 SHALL have port busy  output  NCH  channel in RUN.
REQ-015 SHALL have port done  output  NCH  one-shot channel completed and holding in DONE.

Function
REQ-016 Each channel SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-017 Timebase edge SHALL be detected as clkdiv[tap]=1 while the registered previous sample of clkdiv[tap] is 0.
REQ-018 The previous-sample register SHALL be reloaded with the current clkdiv[tap] on start and on a config write, so no spurious edge occurs.
REQ-019 In RUN, on each edge: if cnt==count, tick SHALL pulse on the next clock (1-cycle latency from the edge at the input) and cnt SHALL clear; otherwise cnt increments.
REQ-020 count=0 SHALL give one tick per timebase edge; count=65535 SHALL tick once per 65536 edges with no overflow.
REQ-021 Periodic mode SHALL stay in RUN after a tick; one-shot SHALL go RUN->DONE with exactly one tick.
REQ-022 start in IDLE or DONE SHALL go to RUN with cnt=0; start in RUN SHALL be ignored.
REQ-023 stop in RUN or DONE SHALL go to IDLE, clearing cnt; no tick SHALL be issued in the stop cycle's result.
REQ-024 start and stop in the same cycle on the same channel SHALL resolve as stop.
REQ-025 cfg_ready SHALL be combinationally high when channel cfg_ch is IDLE or DONE, low when RUN; out-of-range cfg_ch SHALL give cfg_ready=1.
REQ-026 An accepted write SHALL latch tap, count, mode; a DONE channel SHALL then go to IDLE.
REQ-027 A write and a start to the same channel in the same cycle SHALL both take effect; the RUN phase uses the new configuration.
REQ-028 Channels SHALL be fully independent; simultaneous ticks on several channels SHALL all be issued.

Reset
REQ-029 On rst all channels SHALL be IDLE; tap, count, mode, cnt and prev SHALL be 0; tick, busy and done SHALL be 0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately; no tick SHALL be issued until a new start.
REQ-031 After reset release, cfg_ready SHALL be 1.

Structure
REQ-032 Shared package clk_sched_pkg SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2), TAP_W=5, CNT_W=16, and the NCH maximum.
REQ-033 The per-channel FSM, counter and edge detector SHALL be one sub-module, clk_sched_chan, instantiated NCH times by generate.
REQ-034 Config decode and the cfg_ready mux SHALL live in the top level.

Verification
REQ-035 The bench SHALL drive clkdiv from a free-running counter and cover the following scenarios.
REQ-036 ch0 tap=2, count=0, periodic, start -> tick0 every 8 clocks, each pulse 1 cycle wide.
REQ-037 ch1 tap=0, count=3, one-shot, start -> exactly one tick1 after 4 edges (about 8 clocks), then done1=1 and busy1=0.
REQ-038 A write to ch0 while RUN -> cfg_ready=0 and the config is unchanged; stop0 -> IDLE, then the write completes.
REQ-039 start2 and stop2 asserted in the same cycle while IDLE -> ch2 stays IDLE, no tick2.
REQ-040 rst pulsed mid-RUN on all channels -> all outputs 0 the same cycle, no ticks afterwards until restart.
REQ-041 ch3 tap=31, count=0, with clkdiv preloaded near 0x7FFFFFFF -> one tick3 at the bit-31 rise, none at the wrap to 0.
